// File: rtl/mul_div_unit.sv
// mul_div_unit: multicycle HI/LO multiply/divide unit with MTHI/MTLO writes and MFHI/MFLO read
//
// Ports:
//   clk     - sole clock, rising-edge state updates
//   rst_n   - asynchronous active-low reset
//   start   - qualifies MulOp/MTHILO as issued this cycle
//   MulOp   - 000 MULTU, 001 MULT, 010 DIVU, 011 DIV, others none
//   MTHILO  - 00 MTLO, 01 MTHI, others none
//   MFHILO  - 01 read LO, 10 read HI, others read 0
//   A, B    - rs / rt operands (A is also the MT write data)
//   busy    - registered, high while an operation is in flight
//   rdata   - combinational HI/LO read
//   HI, LO  - architectural register values
module mul_div_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  MulOp,
    input  logic [1:0]  MTHILO,
    input  logic [1:0]  MFHILO,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] rdata,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam logic [2:0] OP_NONE = 3'b100;

    logic        r_busy;
    logic [3:0]  r_cnt;
    logic [2:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_accept_op;
    logic        w_accept_mt;
    logic        w_sgn;
    logic        w_is_div;
    logic [63:0] w_prod;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_q_u;
    logic [31:0] w_r_u;
    logic [31:0] w_quo;
    logic [31:0] w_rem;

    // A valid MulOp wins over an MT write issued in the same cycle
    assign w_accept_op = start && !r_busy && !MulOp[2];
    assign w_accept_mt = start && !r_busy && MulOp[2] && !MTHILO[1];

    assign w_sgn    = r_op[0];
    assign w_is_div = (r_op[2:1] == 2'b01);

    // Sign-extending to 64 bits makes the low 64 bits of one multiply correct for both flavours
    assign w_prod = {{32{w_sgn & r_a[31]}}, r_a} * {{32{w_sgn & r_b[31]}}, r_b};

    // Signed divide on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0 without overflow
    assign w_abs_a = (w_sgn && r_a[31]) ? -r_a : r_a;
    assign w_abs_b = (w_sgn && r_b[31]) ? -r_b : r_b;
    assign w_q_u   = w_abs_a / w_abs_b;
    assign w_r_u   = w_abs_a % w_abs_b;
    assign w_quo   = (w_sgn && (r_a[31] ^ r_b[31])) ? -w_q_u : w_q_u;
    assign w_rem   = (w_sgn && r_a[31]) ? -w_r_u : w_r_u;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_cnt  <= 4'd0;
            r_op   <= OP_NONE;
            r_a    <= 32'd0;
            r_b    <= 32'd0;
            r_hi   <= 32'd0;
            r_lo   <= 32'd0;
        end else if (w_accept_op) begin
            r_busy <= 1'b1;
            r_cnt  <= MulOp[1] ? 4'd10 : 4'd5;
            r_op   <= MulOp;
            r_a    <= A;
            r_b    <= B;
        end else if (r_busy) begin
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
                r_busy <= 1'b0;
                r_op   <= OP_NONE;
                if (!w_is_div) begin
                    r_hi <= w_prod[63:32];
                    r_lo <= w_prod[31:0];
                end else if (r_b != 32'd0) begin
                    r_hi <= w_rem;
                    r_lo <= w_quo;
                end
            end
        end else if (w_accept_mt) begin
            if (MTHILO[0])
                r_hi <= A;
            else
                r_lo <= A;
        end
    end

    assign busy  = r_busy;
    assign HI    = r_hi;
    assign LO    = r_lo;
    assign rdata = (MFHILO == 2'b10) ? r_hi : (MFHILO == 2'b01) ? r_lo : 32'd0;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed self-checking bench for mul_div_unit
module tb_mul_div_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  MulOp;
    logic [1:0]  MTHILO;
    logic [1:0]  MFHILO;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] rdata;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks = 0;
    int errors = 0;

    mul_div_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .MulOp(MulOp), .MTHILO(MTHILO),
        .MFHILO(MFHILO), .A(A), .B(B), .busy(busy), .rdata(rdata), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        start  = 1'b0;
        MulOp  = 3'b100;
        MTHILO = 2'b10;
    endtask

    // Drive one issue for exactly one rising edge; returns #1 after that edge
    task automatic issue(input logic [2:0] op, input logic [1:0] mt, input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        MulOp  = op;
        MTHILO = mt;
        A      = a;
        B      = b;
        @(posedge clk);
        #1 idle();
    endtask

    // Called #1 after the accepting edge: busy high until the n-th edge, low after it
    task automatic wait_busy(input int n, input string tag);
        chk({tag, "_busy1"}, {31'd0, busy}, 32'd1);
        repeat (n - 1) @(posedge clk);
        #1 chk({tag, "_busy_last"}, {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1 chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic chk_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
        chk({tag, "_HI"}, HI, hi);
        chk({tag, "_LO"}, LO, lo);
    endtask

    initial begin
        rst_n  = 1'b0;
        MFHILO = 2'b00;
        A      = 32'd0;
        B      = 32'd0;
        idle();
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk_hilo("reset", 32'd0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // MULT -2 * 3, issued on the first edge after reset release
        issue(3'b001, 2'b10, 32'hFFFFFFFE, 32'd3);
        chk("mult_hi_hold", HI, 32'd0);
        wait_busy(5, "mult");
        chk_hilo("mult", 32'hFFFFFFFF, 32'hFFFFFFFA);

        // DIV -7 / 2 and DIVU of the same bits
        issue(3'b011, 2'b10, 32'hFFFFFFF9, 32'd2);
        wait_busy(10, "div");
        chk_hilo("div", 32'hFFFFFFFF, 32'hFFFFFFFD);
        issue(3'b010, 2'b10, 32'hFFFFFFF9, 32'd2);
        wait_busy(10, "divu");
        chk_hilo("divu", 32'd1, 32'h7FFFFFFC);

        // DIV 7 / -2: quotient -3, remainder takes dividend sign (+1)
        issue(3'b011, 2'b10, 32'd7, 32'hFFFFFFFE);
        wait_busy(10, "div_pos_neg");
        chk_hilo("div_pos_neg", 32'd1, 32'hFFFFFFFD);

        // MULTU max*max with a DIVU start on busy cycle 3 that must be ignored
        issue(3'b000, 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1; MulOp = 3'b010; A = 32'd100; B = 32'd7;
        @(posedge clk);
        #1 idle();
        @(posedge clk);
        #1 chk("multu_ovl_busy4", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1 chk("multu_ovl_busy5", {31'd0, busy}, 32'd0);
        chk_hilo("multu_ovl", 32'hFFFFFFFE, 32'h00000001);
        @(posedge clk);
        #1 chk("multu_no_reload", {31'd0, busy}, 32'd0);
        chk_hilo("multu_no_reload", 32'hFFFFFFFE, 32'h00000001);

        // MTHI then MFHI / MFLO / none
        issue(3'b100, 2'b01, 32'h12345678, 32'd0);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        MFHILO = 2'b10;
        #1 chk("mfhi", rdata, 32'h12345678);
        MFHILO = 2'b01;
        #1 chk("mflo", rdata, 32'h00000001);
        MFHILO = 2'b00;
        #1 chk("mf_none", rdata, 32'd0);

        // MTLO while busy is dropped
        issue(3'b000, 2'b10, 32'd2, 32'd3);
        @(posedge clk);
        #1 issue(3'b100, 2'b00, 32'hDEADBEEF, 32'd0);
        chk("mtlo_busy_LO", LO, 32'h00000001);
        repeat (3) @(posedge clk);
        #1 chk("mtlo_busy_done", {31'd0, busy}, 32'd0);
        chk_hilo("multu_small", 32'd0, 32'd6);

        // MulOp beats MTLO in the same accepting cycle
        issue(3'b000, 2'b00, 32'd4, 32'd5);
        chk("prio_LO_kept", LO, 32'd6);
        wait_busy(5, "prio");
        chk_hilo("prio", 32'd0, 32'd20);

        // Divide by zero leaves HI/LO unchanged
        issue(3'b100, 2'b01, 32'hAAAA5555, 32'd0);
        issue(3'b100, 2'b00, 32'h5555AAAA, 32'd0);
        chk_hilo("mt_setup", 32'hAAAA5555, 32'h5555AAAA);
        issue(3'b010, 2'b10, 32'd123, 32'd0);
        wait_busy(10, "divu0");
        chk_hilo("divu0", 32'hAAAA5555, 32'h5555AAAA);
        issue(3'b011, 2'b10, 32'd123, 32'd0);
        wait_busy(10, "div0");
        chk_hilo("div0", 32'hAAAA5555, 32'h5555AAAA);

        // Signed overflow case
        issue(3'b011, 2'b10, 32'h80000000, 32'hFFFFFFFF);
        wait_busy(10, "div_ovf");
        chk_hilo("div_ovf", 32'd0, 32'h80000000);

        // Asynchronous reset on cycle 4 of a DIV
        issue(3'b011, 2'b10, 32'd100, 32'd7);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk_hilo("rst_mid", 32'd0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1 chk("rst_after_busy", {31'd0, busy}, 32'd0);
        chk_hilo("rst_after", 32'd0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port start, input, 1, qualifies MulOp/MTHILO as issued this cycle (E-stage instruction valid, not stalled).
REQ-004 SHALL have port MulOp, input, 3, operation select: 000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 none (other codes = none).
REQ-005 SHALL have port MTHILO, input, 2, register write select: 00 MTLO, 01 MTHI, 10 none (11 = none).
REQ-006 SHALL have port MFHILO, input, 2, read select: 01 LO, 10 HI, 00/11 none.
REQ-007 SHALL have port A, input, 32, rs operand (dividend, multiplicand, MT write data).
REQ-008 SHALL have port B, input, 32, rt operand (divisor, multiplier).
REQ-009 SHALL have port busy, output, 1, registered, high while an operation is in flight.
REQ-010 SHALL have port rdata, output, 32, combinational read of HI/LO per MFHILO.
REQ-011 SHALL have ports HI and LO, output, 32 each, current architectural register values.

Function
REQ-012 SHALL accept an operation at a rising edge when start=1, MulOp in {000..011}, busy=0; operands and op are latched at that edge.
REQ-013 SHALL set busy=1 from the accepting edge for exactly 5 cycles (MULT/MULTU) or 10 cycles (DIV/DIVU), using a down-counter loaded with 5 or 10.
REQ-014 SHALL write HI/LO at the edge that decrements the counter to 0, and clear busy at that same edge.
REQ-015 SHALL ignore start with a valid MulOp while busy=1; no re-latch, counter not reloaded.
REQ-016 SHALL compute MULTU as unsigned 32x32->64 and MULT as two's-complement 32x32->64; HI=product[63:32], LO=product[31:0].
REQ-017 SHALL compute DIVU unsigned and DIV signed with quotient truncated toward zero; LO=quotient, HI=remainder, remainder sign equals dividend sign.
REQ-018 SHALL for DIV 0x80000000 / 0xFFFFFFFF produce LO=0x80000000, HI=0x00000000.
REQ-019 SHALL for divisor 0 (DIV or DIVU) still hold busy 10 cycles and leave HI and LO unchanged at completion.
REQ-020 SHALL on start=1, busy=0, MulOp none, MTHILO=00 write LO<=A; MTHILO=01 write HI<=A, at that edge, with no busy.
REQ-021 SHALL ignore MTHI/MTLO while busy=1 (pipeline stalls the issuer).
REQ-022 SHALL give a valid MulOp priority over MTHILO when both are active in the same accepting cycle; the MT write is dropped.
REQ-023 SHALL drive rdata = HI when MFHILO=10, LO when 01, else 0, from current register values (completion-edge values visible the cycle after).
REQ-024 SHALL never change HI/LO during busy other than at the completion edge.

Reset
REQ-025 SHALL on rst_n=0, regardless of clk, force busy=0, counter=0, HI=0, LO=0, latched op=none.
REQ-026 SHALL abort an in-flight operation on reset mid-operation; no result written after rst_n rises.
REQ-027 SHALL accept a new operation on the first rising edge with rst_n=1.

Verification
REQ-028 SHALL pass: MULT A=0xFFFFFFFE (-2), B=3 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-029 SHALL pass: DIV A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU same operands -> LO=0x7FFFFFFC, HI=1.
REQ-030 SHALL pass: MULTU issued, new DIVU start on cycle 3 of busy -> ignored; busy falls after 5 cycles with MULTU result only.
REQ-031 SHALL pass: MTHI A=0x12345678 then MFHILO=10 next cycle -> rdata=0x12345678; MTLO during busy -> LO unchanged.
REQ-032 SHALL pass: DIVU B=0 with HI=0xAAAA5555, LO=0x5555AAAA -> after 10 cycles both unchanged, busy=0.
REQ-033 SHALL pass: rst_n pulsed low at cycle 4 of a DIV -> busy=0, HI=LO=0 immediately, remaining 0 after counter would have expired.
